// File: rtl/pio_gpio_pkg.sv
// Shared definitions for the PIO GPIO bank: register word addresses and
// the edge-type encodings used by the EDGE_TYPE parameter.
package pio_gpio_pkg;

    // Register word addresses (3-bit address bus)
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    // Edge detection selection
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_gpio_bank_if.sv
// Register bus of the PIO GPIO bank: word address, select, active-low
// write strobe, 32-bit write data and combinational 32-bit read data.
interface pio_gpio_bank_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_gpio_sync.sv
// WIDTH-bit two-flop synchroniser for asynchronous pin inputs.
// Both stages clear asynchronously on reset_n low.
module pio_gpio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops resolve metastability on the pin inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pio_gpio_bank.sv
// PIO GPIO bank: data/direction registers with set/clear aliases, a
// synchronised input path and optional edge capture with a level interrupt.
// Edge capture (irq_mask, edge_capture, prev_in, irq) is built only when
// the macro PIO_GPIO_BANK_EDGE_EN is defined; otherwise addresses 2 and 3
// read 0 and irq is tied low.
module pio_gpio_bank
    import pio_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_gpio_bank_if.slave   bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rd_data;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    // Upper write-data bits beyond WIDTH are intentionally discarded
    assign unused_wdata = ^bus.writedata;

    pio_gpio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (sync_in)
    );

    // Next-state of data_out (direct, set and clear aliases) and direction
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:   data_out_d = wdata;
                ADDR_DIR:    dir_d      = wdata;
                ADDR_OUTSET: data_out_d = data_out_q | wdata;
                ADDR_OUTCLR: data_out_d = data_out_q & ~wdata;
                default:     ;
            endcase
        end
    end

    // Output and direction registers; reset aborts any in-flight write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
        end
    end

    assign out_port = data_out_q;
    assign oe       = dir_q;

`ifdef PIO_GPIO_BANK_EDGE_EN
    logic [WIDTH-1:0] prev_in_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;

    // Edge detect between the synchronised input and its one-cycle delay
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = ~sync_in & prev_in_q;
            EDGE_ANY:  edge_det = sync_in ^ prev_in_q;
            default:   edge_det = sync_in & ~prev_in_q;
        endcase
    end

    // Mask write and write-1-to-clear capture; a new edge beats a clear
    always_comb begin
        irq_mask_d = irq_mask_q;
        edge_clr   = '0;
        if (wr_en && (bus.address == ADDR_IRQMASK)) irq_mask_d = wdata;
        if (wr_en && (bus.address == ADDR_EDGECAP)) edge_clr   = wdata;
        edge_cap_d = (edge_cap_q & ~edge_clr) | edge_det;
    end

    // Edge-capture state; zeroed prev_in may capture spurious edges after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_in_q  <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            prev_in_q  <= sync_in;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    assign irq = |(edge_cap_q & irq_mask_q);
`else
    localparam int unused_edge_type = EDGE_TYPE;
    assign irq = 1'b0;
`endif

    // Combinational read mux; inputs read through for bits configured as input
    always_comb begin
        rd_data = '0;
        case (bus.address)
            ADDR_DATA:    rd_data = (sync_in & ~dir_q) | (data_out_q & dir_q);
            ADDR_DIR:     rd_data = dir_q;
`ifdef PIO_GPIO_BANK_EDGE_EN
            ADDR_IRQMASK: rd_data = irq_mask_q;
            ADDR_EDGECAP: rd_data = edge_cap_q;
`endif
            default:      rd_data = '0;
        endcase
    end

    assign bus.readdata = 32'(rd_data);

endmodule

// File: tb/tb_pio_gpio_bank.sv
// Scoreboard bench for pio_gpio_bank (WIDTH=8, RESET_VALUE=A5, rising edges).
// Works in both builds; the reference model follows PIO_GPIO_BANK_EDGE_EN.
module tb_pio_gpio_bank;
    import pio_gpio_pkg::*;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;
    localparam int         ET = EDGE_RISE;
`ifdef PIO_GPIO_BANK_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    pio_gpio_bank_if bus();

    pio_gpio_bank #(.WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(ET)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .oe       (oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  outp;
        logic [7:0]  oen;
        logic        irqv;
        int          addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: register values plus a history of pin samples
    // (hist[0] = pin value at the latest edge, hist[1] = one edge earlier ...)
    logic [7:0] m_dout, m_dir, m_mask, m_cap;
    logic [7:0] hist [3];

    function automatic void m_reset();
        m_dout = RV;
        m_dir  = '0;
        m_mask = '0;
        m_cap  = '0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
    endfunction

    // The synchronised value is the pin as sampled two edges ago
    function automatic logic [31:0] m_read(int a);
        logic [7:0] v;
        case (a)
            0:       v = (hist[1] & ~m_dir) | (m_dout & m_dir);
            1:       v = m_dir;
            2:       v = m_mask;
            3:       v = m_cap;
            default: v = '0;
        endcase
        return {24'h0, v};
    endfunction

    function automatic void m_step(int a, logic cs, logic wn, logic [31:0] wd, logic [7:0] pin);
        logic [7:0] s, p, det, d;
        s = hist[1];
        p = hist[2];
        d = wd[7:0];
        if (ET == EDGE_FALL)     det = ~s & p;
        else if (ET == EDGE_ANY) det = s ^ p;
        else                     det = s & ~p;
        if (!EDGE_EN) det = '0;
        if (cs && !wn) begin
            case (a)
                0: m_dout = d;
                1: m_dir  = d;
                2: if (EDGE_EN) m_mask = d;
                3: if (EDGE_EN) m_cap  = m_cap & ~d;
                4: m_dout = m_dout | d;
                5: m_dout = m_dout & ~d;
                default: ;
            endcase
        end
        m_cap   = m_cap | det;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pin;
    endfunction

    task automatic drive(int a, logic cs, logic wn, logic [31:0] wd, logic [7:0] pin);
        exp_t e;
        bus.address    = a[2:0];
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        in_port        = pin;
        if (cs && wn) begin
            e.rd   = m_read(a);
            e.outp = m_dout;
            e.oen  = m_dir;
            e.irqv = |(m_cap & m_mask);
            e.addr = a;
            sb.push_back(e);
        end
    endtask

    // One bus cycle: let the edge happen, advance the model, drive the next op
    task automatic op(int a, logic cs, logic wn, logic [31:0] wd, logic [7:0] pin);
        @(posedge clk);
        if (reset_n)
            m_step(bus.address, bus.chipselect, bus.write_n, bus.writedata, in_port);
        #1;
        drive(a, cs, wn, wd, pin);
    endtask

    task automatic wr(int a, logic [31:0] wd, logic [7:0] pin);
        op(a, 1'b1, 1'b0, wd, pin);
    endtask

    task automatic rd(int a, logic [7:0] pin);
        op(a, 1'b1, 1'b1, $urandom, pin);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        else
            passes++;
    endtask

    // Monitor: every read cycle presented to the DUT is matched against the queue
    always @(negedge clk) begin
        if (bus.chipselect === 1'b1 && bus.write_n === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_empty actual=0 required=1 t=%0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("readdata_a%0d", e.addr), bus.readdata, e.rd);
                chk("out_port", {24'h0, out_port}, {24'h0, e.outp});
                chk("oe", {24'h0, oe}, {24'h0, e.oen});
                chk("irq", {31'h0, irq}, {31'h0, e.irqv});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pin;
        m_reset();
        drive(0, 1'b0, 1'b1, 32'h0, 8'h00);

        // Reads of every address while reset is held
        for (int a = 0; a < 8; a++) rd(a, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(0, 1'b0, 1'b1, 32'h0, 8'h00);
        for (int a = 0; a < 8; a++) rd(a, 8'h00);

        // Data write, set alias, clear alias, with garbage upper bits
        wr(0, 32'hDEADBE0F, 8'h00);  rd(0, 8'h00);
        wr(4, 32'hABCDEFF0, 8'h00);  rd(4, 8'h00);
        wr(5, 32'h12345681, 8'h00);  rd(5, 8'h00);
        rd(0, 8'h00);

        // Mixed direction read-back
        wr(1, 32'hFFFF00F0, 8'h0C);
        wr(0, 32'h00000030, 8'h0C);
        for (int i = 0; i < 3; i++) op(0, 1'b0, 1'b1, 32'h0, 8'h0C);
        rd(0, 8'h0C);

        // Clear anything captured so far, enable bit 0, then raise pin 0
        for (int i = 0; i < 3; i++) op(0, 1'b0, 1'b1, 32'h0, 8'h00);
        wr(3, 32'hFFFFFFFF, 8'h00);
        wr(2, 32'h00000001, 8'h00);
        rd(3, 8'h00);
        for (int i = 0; i < 4; i++) rd(3, 8'h01);
        wr(3, 32'h00000001, 8'h01);
        rd(3, 8'h01);

        // Mask toggled while an edge is pending
        for (int i = 0; i < 3; i++) rd(3, 8'h00);
        rd(3, 8'h01);
        for (int i = 0; i < 3; i++) rd(3, 8'h01);
        wr(2, 32'h0, 8'h01);  rd(2, 8'h01);
        wr(2, 32'h1, 8'h01);  rd(2, 8'h01);

        // Clear of bit 0 in the same cycle that a new rising edge is detected
        for (int i = 0; i < 4; i++) rd(3, 8'h00);
        op(0, 1'b0, 1'b1, 32'h0, 8'h01);
        op(0, 1'b0, 1'b1, 32'h0, 8'h01);
        wr(3, 32'h00000001, 8'h01);
        rd(3, 8'h01);
        rd(3, 8'h01);

        // Randomised traffic with toggling pins
        pin = 8'h01;
        for (int i = 0; i < 400; i++) begin
            int a;
            logic cs, wn;
            a   = int'($urandom_range(0, 7));
            cs  = ($urandom_range(0, 9) < 8);
            wn  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) pin = 8'($urandom);
            op(a, cs, wn, $urandom, pin);
        end

        // Reset asserted in the middle of a write cycle
        @(posedge clk);
        if (reset_n)
            m_step(bus.address, bus.chipselect, bus.write_n, bus.writedata, in_port);
        #1;
        drive(0, 1'b1, 1'b0, 32'h00000055, pin);
        #2;
        reset_n = 1'b0;
        m_reset();
        drive(0, 1'b1, 1'b1, 32'h0, pin);
        for (int a = 1; a < 4; a++) rd(a, pin);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(0, 1'b0, 1'b1, 32'h0, pin);

        // Post-reset spurious capture stays masked until software acts
        for (int i = 0; i < 4; i++) rd(3, pin);
        for (int i = 0; i < 100; i++) begin
            int a;
            logic cs, wn;
            a   = int'($urandom_range(0, 7));
            cs  = ($urandom_range(0, 9) < 8);
            wn  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 0) pin = 8'($urandom);
            op(a, cs, wn, $urandom, pin);
        end
        op(0, 1'b0, 1'b1, 32'h0, pin);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pio_gpio_bank.md
PIO_GPIO_BANK -- requirements
Module: pio_gpio_bank

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of GPIO bits; the legal range SHALL be 1..32.
REQ-002 Parameter RESET_VALUE, default 0, SHALL set the data_out register value after reset.
REQ-003 Parameter EDGE_TYPE, default 0, SHALL select edge detection: 0 rising, 1 falling, 2 any.
REQ-004 Port clk, input, 1 bit, SHALL be the system clock; all state updates occur on its rising edge.
REQ-005 Port reset_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-006 Port address, input, 3 bits, SHALL be the register word select.
REQ-007 Port chipselect, input, 1 bit, SHALL be the slave select.
REQ-008 Port write_n, input, 1 bit, SHALL be the active-low write strobe.
REQ-009 Port writedata, input, 32 bits, SHALL carry write data.
REQ-010 Port readdata, output, 32 bits, SHALL carry read data, combinational from address and registers.
REQ-011 Port in_port, input, WIDTH bits, SHALL carry the asynchronous pin inputs.
REQ-012 Port out_port, output, WIDTH bits, SHALL equal data_out.
REQ-013 Port oe, output, WIDTH bits, SHALL equal the direction register (1 = output).
REQ-014 Port irq, output, 1 bit, SHALL be the level interrupt.

Function
REQ-015 A write SHALL occur when chipselect=1 and write_n=0, and SHALL take effect at that clock edge.
REQ-016 Writes SHALL ignore writedata[31:WIDTH]; readdata[31:WIDTH] SHALL read as 0.
REQ-017 Address 0 (data) SHALL write data_out; reads SHALL return sync_in for bits where direction=0 and data_out for bits where direction=1.
REQ-018 Address 1 (direction) SHALL be read/write.
REQ-019 Address 2 (irq_mask) SHALL be read/write.
REQ-020 Address 3 (edge_capture) SHALL be readable; each written 1 clears that bit, and written 0s have no effect.
REQ-021 Address 4 (outset) SHALL update data_out to data_out | writedata.
REQ-022 Address 5 (outclear) SHALL update data_out to data_out & ~writedata.
REQ-023 Addresses 4 and 5 SHALL read 0.
REQ-024 Addresses 6 and 7 SHALL read 0, and writes to them SHALL be ignored.
REQ-025 in_port SHALL pass through a 2-flop synchroniser to produce sync_in; a third register prev_in SHALL hold sync_in delayed by one cycle.
REQ-026 An edge on bit i SHALL be detected when sync_in[i] differs from prev_in[i] in the direction selected by EDGE_TYPE.
REQ-027 A detected edge SHALL set edge_capture[i] at the next clock edge, regardless of direction or mask.
REQ-028 Latency: an in_port change that is stable before clock edge k SHALL be visible in edge_capture after edge k+2.
REQ-029 When a write-1-to-clear and a new edge hit the same bit in the same cycle, the set SHALL win.
REQ-030 irq SHALL equal |(edge_capture & irq_mask), combinational from registers, and SHALL stay asserted until software clears it.
REQ-031 Writing the mask while a captured edge is pending SHALL assert or deassert irq in the following cycle, with no lost edges.

Reset
REQ-032 Asserting reset_n low SHALL immediately set data_out=RESET_VALUE and direction=0.
REQ-033 Asserting reset_n low SHALL immediately set irq_mask=0, edge_capture=0, and the synchroniser and prev_in registers to 0.
REQ-034 During reset, irq SHALL be 0, out_port SHALL equal RESET_VALUE, and oe SHALL be 0.
REQ-035 Reset asserted mid-write SHALL abort the write.
REQ-036 After reset release, spurious edges from the zeroed synchroniser SHALL be masked by irq_mask=0 but still captured, and software clears them.

Configuration
REQ-037 Macro PIO_GPIO_BANK_EDGE_EN SHALL control edge-capture support.
REQ-038 With PIO_GPIO_BANK_EDGE_EN defined, REQ-019..020 and REQ-026..031 SHALL apply.
REQ-039 Without PIO_GPIO_BANK_EDGE_EN, the edge_capture and irq_mask registers and prev_in SHALL not exist, addresses 2 and 3 SHALL read 0 and ignore writes, and irq SHALL be tied to 0.
REQ-040 Without PIO_GPIO_BANK_EDGE_EN, the synchroniser and the data read path SHALL be unchanged.

Structure
REQ-041 Shared package pio_gpio_pkg SHALL hold the register address constants (ADDR_DATA..ADDR_OUTCLR) and the EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
REQ-042 Sub-module pio_gpio_sync SHALL implement the parametrised WIDTH-bit 2-flop synchroniser with asynchronous reset; all other logic SHALL be inline.

Verification
REQ-043 Reset, then read addr 0..7 with WIDTH=8 and RESET_VALUE=8'hA5 -> out_port=A5, oe=0, all reads 0 except addr0, which returns sync_in.
REQ-044 Write data=0x0F, then outset=0xF0, then outclear=0x81 -> out_port 0F, FF, 7E on successive cycles; writedata[31:8] garbage has no effect.
REQ-045 direction=0xF0, data_out=0x30, in_port=0x0C held 3 cycles -> addr0 reads 0x3C.
REQ-046 EDGE_TYPE=0, mask=0x01, raise in_port[0] before edge k -> edge_capture[0]=1 and irq=1 after edge k+2; write 0x01 to addr3 -> irq=0 next cycle.
REQ-047 Clear of bit 0 coincident with a new rising edge on bit 0 -> edge_capture[0] stays 1 and irq remains asserted.
REQ-048 Build without PIO_GPIO_BANK_EDGE_EN and toggle in_port repeatedly -> irq constantly 0, addresses 2 and 3 read 0.
